// File: rtl/anim_pkg.sv
// Shared constants and state encoding for the sprite animation path
// (sequencer, ROM and renderer all import this package).
package anim_pkg;

  localparam int ANIM_FIRST = 0;
  localparam int ANIM_LAST  = 3;
  localparam int IDLE_ADDR  = 4;
  localparam int ADDR_W     = 4;

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } anim_state_t;

endpackage

// File: rtl/anim_hold_timer.sv
// Frame hold timer: counts up to HOLD_TICKS-1 while enabled and saturates
// there, so "expired" stays high until the sequencer clears it on the next
// address change.
module anim_hold_timer #(
  parameter int HOLD_TICKS = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = $clog2(HOLD_TICKS);
  localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);

  logic [CW-1:0] count;

  // Saturating counter; a clear wins over counting so a new frame starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/anim_frame_sequencer.sv
// Animation frame sequencer: steps the sprite ROM address through the walk
// frames, holding each for HOLD_TICKS clocks and never moving on until the
// renderer has acknowledged the current frame. Parks on the idle frame when
// stopped or when a one-shot sequence finishes.
module anim_frame_sequencer #(
  parameter int HOLD_TICKS = 12_500_000,
  parameter int ANIM_LAST  = anim_pkg::ANIM_LAST,
  parameter int IDLE_ADDR  = anim_pkg::IDLE_ADDR,
  parameter int ADDR_W     = anim_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              disp_ack,
  output logic [ADDR_W-1:0] adress,
  output logic              frame_valid,
  output logic              busy,
  output logic              done
);

  import anim_pkg::*;

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(ANIM_FIRST);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(ANIM_LAST);
  localparam logic [ADDR_W-1:0] IDLE_A  = ADDR_W'(IDLE_ADDR);

  anim_state_t       state, state_next;
  logic [ADDR_W-1:0] adress_next;
  logic              frame_valid_next;
  logic              done_next;
  logic              acked, acked_next;
  logic              addr_change;
  logic              expired;
  logic              ack_now;
  logic              advance;

  anim_hold_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (addr_change),
    .en     (state == S_PLAY),
    .expired(expired)
  );

  assign ack_now = frame_valid && disp_ack;
  assign advance = expired && (acked || ack_now);
  assign busy    = (state == S_PLAY);

  // Register state and all registered outputs; reset shows the idle frame as pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      adress      <= IDLE_A;
      frame_valid <= 1'b1;
      done        <= 1'b0;
      acked       <= 1'b0;
    end else begin
      state       <= state_next;
      adress      <= adress_next;
      frame_valid <= frame_valid_next;
      done        <= done_next;
      acked       <= acked_next;
    end
  end

  // Next-state logic; any address change supersedes a pending frame and re-arms the handshake.
  always_comb begin
    state_next       = state;
    adress_next      = adress;
    frame_valid_next = frame_valid;
    done_next        = 1'b0;
    acked_next       = acked;
    addr_change      = 1'b0;

    if (ack_now) begin
      frame_valid_next = 1'b0;
      acked_next       = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_next  = S_PLAY;
          adress_next = FIRST_A;
          addr_change = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_next  = S_IDLE;
          adress_next = IDLE_A;
          addr_change = 1'b1;
        end else if (advance) begin
          addr_change = 1'b1;
          if (adress < LAST_A) begin
            adress_next = adress + 1'b1;
          end else if (loop_en) begin
            adress_next = FIRST_A;
          end else begin
            state_next  = S_IDLE;
            adress_next = IDLE_A;
            done_next   = 1'b1;
          end
        end
      end
      default: begin
        state_next  = S_IDLE;
        adress_next = IDLE_A;
        addr_change = 1'b1;
      end
    endcase

    if (addr_change) begin
      frame_valid_next = 1'b1;
      acked_next       = 1'b0;
    end
  end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Self-checking bench for anim_frame_sequencer with a short hold time.
// Expected frame addresses are queued when playback is kicked off and
// popped each time the DUT moves to a new address.
module tb_anim_frame_sequencer;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic       disp_ack = 1'b0;
  logic [3:0] adress;
  logic       frame_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  anim_frame_sequencer #(
    .HOLD_TICKS(HOLD),
    .ANIM_LAST (3),
    .IDLE_ADDR (4),
    .ADDR_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .disp_ack   (disp_ack),
    .adress     (adress),
    .frame_valid(frame_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (adress !== 4'd4 || frame_valid !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: adress=%0d fv=%b busy=%b done=%b, want 4 1 0 0", adress, frame_valid, busy, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (adress !== 4'd4 || frame_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_release: adress=%0d fv=%b busy=%b, want 4 1 0", adress, frame_valid, busy);
    end
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ack_drops_valid: fv=%b want 0", frame_valid);
    end
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    checks++;
    if (frame_valid !== 1'b0 || adress !== 4'd4) begin
      errors++;
      $display("[TB] FAIL idle_stray_ack: fv=%b adress=%0d, want 0 4", frame_valid, adress);
    end
  endtask

  task automatic test_loop();
    logic [3:0] prev;
    int run;
    int e;
    bit bad;
    bad = 1'b0;
    exp_q = {};
    for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
    loop_en  = 1'b1;
    disp_ack = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (adress !== 4'(e) || busy !== 1'b1 || frame_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loop_first: adress=%0d busy=%b fv=%b, want %0d 1 1", adress, busy, frame_valid, e);
    end
    prev = adress;
    run  = 1;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      if (adress !== prev) begin
        checks++;
        if (run != HOLD) begin
          errors++;
          $display("[TB] FAIL loop_hold: frame %0d held %0d cycles, want %0d", prev, run, HOLD);
        end
        e = exp_q.pop_front();
        checks++;
        if (adress !== 4'(e)) begin
          errors++;
          $display("[TB] FAIL loop_addr: adress=%0d want %0d", adress, e);
        end
        prev = adress;
        run  = 1;
      end else begin
        run++;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL loop_timeout: %0d frames never appeared, want 0", exp_q.size());
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL loop_flags: busy/done wrong during loop, want busy=1 done=0");
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [3:0] prev;
    int run;
    int e;
    int done_cnt;
    done_cnt = 0;
    exp_q = {};
    for (int k = 0; k < 4; k++) exp_q.push_back(k);
    exp_q.push_back(4);
    loop_en  = 1'b0;
    disp_ack = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (adress !== 4'(e)) begin
      errors++;
      $display("[TB] FAIL oneshot_first: adress=%0d want %0d", adress, e);
    end
    prev = adress;
    run  = 1;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      if (adress !== prev) begin
        checks++;
        if (run != HOLD) begin
          errors++;
          $display("[TB] FAIL oneshot_hold: frame %0d held %0d cycles, want %0d", prev, run, HOLD);
        end
        e = exp_q.pop_front();
        checks++;
        if (adress !== 4'(e)) begin
          errors++;
          $display("[TB] FAIL oneshot_addr: adress=%0d want %0d", adress, e);
        end
        prev = adress;
        run  = 1;
      end else begin
        run++;
      end
    end
    checks++;
    if (adress !== 4'd4 || done !== 1'b1 || busy !== 1'b0 || frame_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oneshot_end: adress=%0d done=%b busy=%b fv=%b, want 4 1 0 1", adress, done, busy, frame_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || adress !== 4'd4 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL oneshot_done_pulse: done=%b adress=%0d pulses=%0d, want 0 4 1", done, adress, done_cnt);
    end
  endtask

  task automatic test_stall();
    int e;
    bit bad;
    bad = 1'b0;
    exp_q = {};
    exp_q.push_back(1);
    loop_en  = 1'b1;
    disp_ack = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && adress !== 4'd1; c++) tick();
    e = exp_q.pop_front();
    checks++;
    if (adress !== 4'(e)) begin
      errors++;
      $display("[TB] FAIL stall_reach: adress=%0d want %0d", adress, e);
    end
    disp_ack = 1'b0;
    exp_q.push_back(2);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (adress !== 4'd1 || frame_valid !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL stall_hold: adress=%0d fv=%b, want 1 1 throughout stall", adress, frame_valid);
    end
    disp_ack = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (adress !== 4'(e) || frame_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: adress=%0d fv=%b, want %0d 1", adress, frame_valid, e);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_abort();
    loop_en  = 1'b1;
    disp_ack = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && adress !== 4'd2; c++) tick();
    disp_ack = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (adress !== 4'd4 || done !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort: adress=%0d done=%b busy=%b fv=%b, want 4 0 0 1", adress, done, busy, frame_valid);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    checks++;
    if (adress !== 4'd4 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_stop_collision: adress=%0d busy=%b, want 4 0", adress, busy);
    end
    disp_ack = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (adress !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_play: adress=%0d busy=%b, want 0 1", adress, busy);
    end
    tick();
    tick();
    checks++;
    if (adress !== 4'd1) begin
      errors++;
      $display("[TB] FAIL start_no_restart: adress=%0d want 1", adress);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_mid_reset();
    loop_en  = 1'b0;
    disp_ack = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && adress !== 4'd3; c++) tick();
    checks++;
    if (adress !== 4'd3) begin
      errors++;
      $display("[TB] FAIL midreset_reach: adress=%0d want 3", adress);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (adress !== 4'd4 || frame_valid !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset: adress=%0d fv=%b busy=%b done=%b, want 4 1 0 0", adress, frame_valid, busy, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (adress !== 4'd4 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_after: adress=%0d busy=%b done=%b, want 4 0 0", adress, busy, done);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_stall();
    test_abort();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
